// File: rtl/aeolus_pkg.sv
// Shared constants for the aeolus multi-cycle core: opcodes, FSM encoding, ALU selects.
package aeolus_pkg;

  localparam int unsigned DATA_W_DEF = 4;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned OP_W       = 4;

  localparam logic [OP_W-1:0] OP_LDA  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDB  = 4'h1;
  localparam logic [OP_W-1:0] OP_LDO  = 4'h2;
  localparam logic [OP_W-1:0] OP_LDSA = 4'h3;
  localparam logic [OP_W-1:0] OP_LDSB = 4'h4;
  localparam logic [OP_W-1:0] OP_LSH  = 4'h5;
  localparam logic [OP_W-1:0] OP_RSH  = 4'h6;
  localparam logic [OP_W-1:0] OP_CLR  = 4'h7;
  localparam logic [OP_W-1:0] OP_SNZA = 4'h8;
  localparam logic [OP_W-1:0] OP_SNZS = 4'h9;
  localparam logic [OP_W-1:0] OP_ADD  = 4'hA;
  localparam logic [OP_W-1:0] OP_SUB  = 4'hB;
  localparam logic [OP_W-1:0] OP_AND  = 4'hC;
  localparam logic [OP_W-1:0] OP_OR   = 4'hD;
  localparam logic [OP_W-1:0] OP_XOR  = 4'hE;
  localparam logic [OP_W-1:0] OP_INV  = 4'hF;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_WB    = 2'd2;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_INV = 3'd5
  } alu_op_e;

endpackage

// File: rtl/aeolus_alu.sv
// Combinational add/sub/logic unit; carry_o is carry for ADD and borrow for SUB.
module aeolus_alu
  import aeolus_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  alu_op_e           op_i,
  output logic [DATA_W-1:0] res_o,
  output logic              carry_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum     = {1'b0, a_i} + {1'b0, b_i};
    diff    = {1'b0, a_i} - {1'b0, b_i};
    res_o   = sum[DATA_W-1:0];
    carry_o = 1'b0;
    case (op_i)
      ALU_ADD: begin res_o = sum[DATA_W-1:0];  carry_o = sum[DATA_W];  end
      ALU_SUB: begin res_o = diff[DATA_W-1:0]; carry_o = diff[DATA_W]; end
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      ALU_XOR: res_o = a_i ^ b_i;
      ALU_INV: res_o = ~a_i;
      default: res_o = sum[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/aeolus_mc_core.sv
// Fetch/exec/writeback accumulator core with synchronous-ROM program fetch.
// Optional single-step input step_req when AEOLUS_STEP_EN is defined.
module aeolus_mc_core
  import aeolus_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2*DATA_W-1:0] switches,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [OP_W-1:0]     rom_data,
`ifdef AEOLUS_STEP_EN
  input  logic                step_req,
`endif
  output logic [DATA_W-1:0]   cpu_out,
  output logic                of_flag,
  output logic                sf_flag,
  output logic                instr_done
);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, s_q, s_d, acc_q, acc_d;
  logic [DATA_W-1:0] o_q, o_d, obuf_q, obuf_d;
  logic              of_q, of_d, sf_q, sf_d, take_q, take_d;
  logic [OP_W-1:0]   op_q, op_d;

  logic              step_ok;
  logic              done_c;
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic              alu_carry;
  alu_op_e           alu_op;

`ifdef AEOLUS_STEP_EN
  assign step_ok = step_req;
`else
  assign step_ok = 1'b1;
`endif

  aeolus_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i     (alu_a),
    .b_i     (alu_b),
    .op_i    (alu_op),
    .res_o   (alu_res),
    .carry_o (alu_carry)
  );

  // Next-state and datapath updates; EXEC decodes rom_data directly, WB uses latched op_q.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    acc_d   = acc_q;
    o_d     = o_q;
    obuf_d  = obuf_q;
    of_d    = of_q;
    sf_d    = sf_q;
    take_d  = take_q;
    op_d    = op_q;
    alu_a   = a_q;
    alu_b   = b_q;
    alu_op  = ALU_ADD;
    done_c  = 1'b0;

    case (state_q)
      ST_FETCH: if (step_ok) state_d = ST_EXEC;
      ST_EXEC: begin
        op_d = rom_data;
        case (rom_data)
          OP_LDA:  a_d = switches[2*DATA_W-1:DATA_W];
          OP_LDB:  b_d = switches[DATA_W-1:0];
          OP_LDO:  obuf_d = acc_q;
          OP_LDSA: s_d = a_q;
          OP_LDSB: s_d = b_q;
          OP_LSH:  begin s_d = s_q << 1; sf_d = s_q[DATA_W-1]; end
          OP_RSH:  begin s_d = s_q >> 1; sf_d = s_q[0]; end
          OP_CLR:  acc_d = '0;
          OP_SNZA, OP_SNZS: take_d = sf_q;
          OP_ADD:  begin alu_op = ALU_ADD; acc_d = alu_res; of_d = alu_carry; end
          OP_SUB:  begin alu_op = ALU_SUB; acc_d = alu_res; of_d = alu_carry; end
          OP_AND:  begin alu_op = ALU_AND; acc_d = alu_res; end
          OP_OR:   begin alu_op = ALU_OR;  acc_d = alu_res; end
          OP_XOR:  begin alu_op = ALU_XOR; acc_d = alu_res; end
          OP_INV:  begin alu_op = ALU_INV; acc_d = alu_res; end
          default: ;
        endcase
        if (rom_data == OP_LDO || rom_data == OP_SNZA || rom_data == OP_SNZS) begin
          state_d = ST_WB;
        end else begin
          state_d = ST_FETCH;
          done_c  = 1'b1;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        done_c  = 1'b1;
        alu_a   = acc_q;
        alu_b   = (op_q == OP_SNZS) ? s_q : a_q;
        if (op_q == OP_LDO) begin
          o_d = obuf_q;
        end else if (take_q) begin
          acc_d = alu_res;
          of_d  = alu_carry;
        end
      end
      default: state_d = ST_FETCH;
    endcase

    if (done_c) pc_d = pc_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      acc_q   <= '0;
      o_q     <= '0;
      obuf_q  <= '0;
      of_q    <= 1'b0;
      sf_q    <= 1'b0;
      take_q  <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      acc_q   <= acc_d;
      o_q     <= o_d;
      obuf_q  <= obuf_d;
      of_q    <= of_d;
      sf_q    <= sf_d;
      take_q  <= take_d;
      op_q    <= op_d;
    end
  end

  assign rom_addr   = pc_q;
  assign cpu_out    = o_q;
  assign of_flag    = of_q;
  assign sf_flag    = sf_q;
  assign instr_done = done_c & ~reset;

endmodule
